imem_uart_loader: RTL and testbench
===================================

# imem_uart_loader

Serial boot loader for the single-cycle CPU's instruction memory. It receives a framed program image over a UART RX line and writes it word by word into the instruction ROM/RAM through the memory's write port. It holds the CPU in reset until a complete, valid image is stored. It is the writer end of the instruction-memory interface; the CPU fetch path is the reader.

## Interface
Parameters:
- BAUD_DIV, 434: clock cycles per UART bit (50 MHz / 115200). Minimum value is 4.
- ADDR_W, 5: instruction-memory word-address width. Must satisfy ADDR_W ≤ 8.

Ports:
- CLOCK_50  in  1  system clock; the block has one clock.
- reset_n  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input; idles high; 8N1 framing, LSB first.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word.
- cpu_reset  out  1  active-high reset, driven to the CPU's reset input.
- load_done  out  1  high while a valid image is resident.
- load_err  out  1  high while in ERROR.

## Operation
- Frame format: header 0xA5, then count byte N, then N×4 data bytes, little-endian per word. With LOADER_CHECKSUM_EN defined, one checksum byte follows the data.
- FSM states: IDLE, COUNT, DATA, CHECK, DONE, ERROR.
- IDLE: a received byte equal to 0xA5 moves to COUNT. Any other byte is ignored.
- COUNT: if N = 0 or N > 2^ADDR_W, go to ERROR. Otherwise latch N, clear the word address and byte index, and go to DATA.
- DATA: byte k of the current word goes to bits [8k+7:8k].
  - After byte 3: imem_we pulses, imem_addr increments, and the word counter increments.
  - After word N: go to CHECK if checksum is enabled, otherwise go to DONE.
- CHECK: the received byte must equal the XOR of all data bytes. On a match go to DONE; otherwise go to ERROR.
- DONE: cpu_reset = 0 and load_done = 1. A new 0xA5 header reasserts cpu_reset, clears load_done, and enters COUNT, which allows a reload.
- ERROR: cpu_reset = 1 and load_err = 1. A 0xA5 header clears load_err and enters COUNT.
- RX framing error (start bit not low at mid-bit, or stop bit = 0): the byte is discarded. In COUNT, DATA or CHECK the FSM goes to ERROR; in IDLE, DONE and ERROR the byte is ignored.
- Writes already performed are never rolled back. The CPU stays in reset until DONE, so partial images are never executed.

## Timing
- Reset values: imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_reset = 1, load_done = 0, load_err = 0, FSM = IDLE.
- uart_rx passes through a 2-flop synchronizer. A start edge is detected on the synchronized falling edge.
- Sampling:
  - start bit at BAUD_DIV/2 cycles after the edge;
  - data bits at +BAUD_DIV each;
  - stop bit at +BAUD_DIV after the last data bit.
- rx_valid pulses one cycle after the stop-bit sample. The receiver is re-armed in the same cycle, so back-to-back bytes are accepted.
- imem_we is registered: it is high exactly one cycle, the cycle after the rx_valid of the 4th byte.
  - imem_addr and imem_wdata are stable during that cycle.
  - imem_addr increments on the following edge.
- cpu_reset deasserts on the edge after the final accepting rx_valid, which is either the 4th byte of the last word or the checksum byte.
- Asserting reset_n low at any point aborts the frame and returns every output to its reset value immediately.

## Configuration
- LOADER_CHECKSUM_EN defined: CHECK state, XOR accumulator and checksum byte are present.
- LOADER_CHECKSUM_EN undefined: no CHECK state; the FSM enters DONE directly after the last word.

## Structure
- loader_pkg holds:
  - the state enum;
  - LOADER_HDR = 8'hA5;
  - UART constants (data bits = 8).
- Sub-module uart_rx_byte contains the synchronizer, bit timer and shift register. Its outputs are rx_data[7:0], rx_valid and rx_ferr.
- The top level contains the FSM, word assembler, address counter and checksum.

## Test plan
- BAUD_DIV = 8, checksum enabled. Send A5, 02, 13 00 00 20, 08 00 00 08, checksum 0x33.
  - Expect writes addr0 = 0x20000013 and addr1 = 0x08000008.
  - Expect cpu_reset to fall and load_done = 1 one cycle after the checksum's rx_valid.
- Same frame with checksum 0x00: expect load_err = 1, cpu_reset stays 1, and exactly 2 writes.
- Send 55, then A5, 00: expect no writes, the 55 ignored, and ERROR after the count byte.
- Send a byte with stop bit = 0 in the middle of DATA: expect ERROR. A following valid frame must load correctly from addr 0.
- After DONE, send a new A5 frame with N = 1: cpu_reset reasserts at the header, the write goes to addr 0, and DONE is reached again.
- Drop reset_n mid-DATA: all outputs return to reset values asynchronously and the FSM returns to IDLE.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory UART boot loader.
// Optional LOADER_CHECKSUM_EN adds the CHECK state and trailing XOR checksum byte.
package loader_pkg;

    localparam logic [7:0] LOADER_HDR     = 8'hA5;
    localparam int         UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERROR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling timer, LSB-first shifter.
// Reports good bytes on rx_valid and bad start/stop bits on rx_ferr.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int            CW   = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [2:0]    LAST = 3'(UART_DATA_BITS - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_prev;
    rx_state_t     r_st;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_valid;
    logic          r_ferr;
    logic          w_fall;
    logic          w_tick;

    assign w_fall   = r_prev & ~r_sync2;
    assign w_tick   = (r_cnt == '0);
    assign rx_data  = r_shift;
    assign rx_valid = r_valid;
    assign rx_ferr  = r_ferr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_st    <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            unique case (r_st)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_cnt <= HALF;
                        r_st  <= RX_START;
                    end
                end
                RX_START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else if (r_sync2) begin
                        r_ferr <= 1'b1;
                        r_st   <= RX_IDLE;
                    end else begin
                        r_cnt <= FULL;
                        r_bit <= '0;
                        r_st  <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_shift <= {r_sync2, r_shift[7:1]};
                        r_cnt   <= FULL;
                        if (r_bit == LAST) begin
                            r_st <= RX_STOP;
                        end else begin
                            r_bit <= r_bit + 3'(1);
                        end
                    end
                end
                RX_STOP: begin
                    // Back to idle on the sample so the next start edge is caught.
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_valid <= r_sync2;
                        r_ferr  <= ~r_sync2;
                        r_st    <= RX_IDLE;
                    end
                end
                default: r_st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// UART boot loader writing a framed image into instruction memory, CPU held in reset.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_uart_loader
    import loader_pkg::*;
#(
    parameter int BAUD_DIV = 434,
    parameter int ADDR_W   = 5
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [8:0] MAX_N = 9'(1 << ADDR_W);

    logic [7:0]        w_rx_data;
    logic              w_rx_valid;
    logic              w_rx_ferr;
    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [8:0]        r_count;
    logic [8:0]        r_words;
    logic [1:0]        r_idx;
    logic [23:0]       r_word;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_err;
    logic              w_in_frame;
    logic              w_last_word;
    logic              w_bad_n;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    uart_rx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .i_clk    (CLOCK_50),
        .i_rst_n  (reset_n),
        .i_rx     (uart_rx),
        .rx_data  (w_rx_data),
        .rx_valid (w_rx_valid),
        .rx_ferr  (w_rx_ferr)
    );

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_reset  = r_cpu_reset;
    assign load_done  = r_done;
    assign load_err   = r_err;

    assign w_last_word = (r_idx == 2'd3) && ((r_words + 9'(1)) == r_count);
    assign w_bad_n     = (w_rx_data == 8'd0) || ({1'b0, w_rx_data} > MAX_N);

`ifdef LOADER_CHECKSUM_EN
    assign w_in_frame = (r_state == S_COUNT) || (r_state == S_DATA) ||
                        (r_state == S_CHECK);
`else
    assign w_in_frame = (r_state == S_COUNT) || (r_state == S_DATA);
`endif

    always_comb begin
        w_next = r_state;
        if (w_rx_ferr) begin
            if (w_in_frame) begin
                w_next = S_ERROR;
            end
        end else if (w_rx_valid) begin
            unique case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (w_rx_data == LOADER_HDR) begin
                        w_next = S_COUNT;
                    end
                end
                S_COUNT: w_next = w_bad_n ? S_ERROR : S_DATA;
                S_DATA: begin
                    if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                        w_next = S_CHECK;
`else
                        w_next = S_DONE;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHECK: w_next = (w_rx_data == r_csum) ? S_DONE : S_ERROR;
`endif
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_words     <= '0;
            r_idx       <= '0;
            r_word      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
        end else begin
            r_state     <= w_next;
            r_we        <= 1'b0;
            // Status flags follow the next state so they change with the accepting edge.
            r_cpu_reset <= (w_next != S_DONE);
            r_done      <= (w_next == S_DONE);
            r_err       <= (w_next == S_ERROR);
            if (r_we) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_rx_valid && (r_state == S_COUNT) && !w_bad_n) begin
                r_count <= {1'b0, w_rx_data};
                r_words <= '0;
                r_idx   <= '0;
                r_addr  <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_csum  <= '0;
`endif
            end
            if (w_rx_valid && (r_state == S_DATA)) begin
                r_idx <= r_idx + 2'(1);
`ifdef LOADER_CHECKSUM_EN
                r_csum <= r_csum ^ w_rx_data;
`endif
                unique case (r_idx)
                    2'd0: r_word[7:0]   <= w_rx_data;
                    2'd1: r_word[15:8]  <= w_rx_data;
                    2'd2: r_word[23:16] <= w_rx_data;
                    2'd3: begin
                        r_we    <= 1'b1;
                        r_wdata <= {w_rx_data, r_word};
                        r_words <= r_words + 9'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Self-checking bench for imem_uart_loader: frame table, write scoreboard, corner sequences.
// Adapts to builds with or without LOADER_CHECKSUM_EN.
module tb_imem_uart_loader;
    import loader_pkg::*;

    localparam int BAUD   = 8;
    localparam int ADDR_W = 5;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          bad;
        bit          exp_done;
    } vec_t;

    logic              clk;
    logic              reset_n;
    logic              uart_rx;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;

    int  n_vec;
    int  n_err;
    wr_t sb[$];
    logic we_prev;

    imem_uart_loader #(
        .BAUD_DIV (BAUD),
        .ADDR_W   (ADDR_W)
    ) u_dut (
        .CLOCK_50   (clk),
        .reset_n    (reset_n),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every write strobe pops one expected {addr, data}.
    always @(negedge clk) begin
        if (reset_n) begin
            if (imem_we) begin
                chk("we_pulse", {31'd0, we_prev}, 32'd0);
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexp_we: got addr %h data %h expected none",
                             imem_addr, imem_wdata);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    chk("wr_addr", {27'd0, imem_addr}, {27'd0, e.addr});
                    chk("wr_data", imem_wdata, e.data);
                end
            end
            we_prev = imem_we;
        end else begin
            we_prev = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BAUD) @(negedge clk);
        end
        uart_rx = stop_v;
        repeat (BAUD) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
    endtask

    // Final accepting byte: cpu_reset must still be high at its rx_valid, low one cycle later.
    task automatic watch_done();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (u_dut.w_rx_valid) begin
                seen = 1'b1;
                chk("rst_at_rxv", {31'd0, cpu_reset}, 32'd1);
                @(negedge clk);
                chk("rst_fall", {31'd0, cpu_reset}, 32'd0);
                chk("done_rise", {31'd0, load_done}, 32'd1);
            end
        end
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL rxv_timeout: got no rx_valid expected one");
        end
    endtask

    function automatic logic [31:0] word_k(int k, logic [31:0] w0, logic [31:0] w1);
        if (k == 0) return w0;
        if (k == 1) return w1;
        return w0 ^ 32'(k);
    endfunction

    task automatic run_frame(input int n, input logic [31:0] w0, input logic [31:0] w1,
                             input bit bad, input bit watch);
        logic [7:0]  q[$];
        logic [7:0]  cs;
        logic [31:0] w;
        wr_t         e;
        cs = 8'h00;
        q.push_back(8'hA5);
        q.push_back(8'(n));
        if (n >= 1 && n <= 32) begin
            for (int k = 0; k < n; k++) begin
                w = word_k(k, w0, w1);
                for (int j = 0; j < 4; j++) begin
                    q.push_back(w[8*j +: 8]);
                    cs = cs ^ w[8*j +: 8];
                end
                e.addr = 5'(k);
                e.data = w;
                sb.push_back(e);
            end
            if (CS) q.push_back(bad ? (cs ^ 8'hFF) : cs);
        end
        for (int i = 0; i < q.size(); i++) begin
            if (watch && i == q.size() - 1) begin
                fork
                    send_byte(q[i], 1'b1);
                    watch_done();
                join
            end else begin
                send_byte(q[i], 1'b1);
            end
        end
    endtask

    task automatic chk_status(input string nm, input bit done);
        chk({nm, "_done"}, {31'd0, load_done}, {31'd0, done});
        chk({nm, "_err"}, {31'd0, load_err}, {31'd0, !done});
        chk({nm, "_cpurst"}, {31'd0, cpu_reset}, {31'd0, !done});
        chk({nm, "_sb"}, 32'(sb.size()), 32'd0);
    endtask

    vec_t tbl[6];

    initial begin
        n_vec   = 0;
        n_err   = 0;
        we_prev = 1'b0;
        uart_rx = 1'b1;
        reset_n = 1'b0;
        tbl[0] = '{2, 32'h2000_0013, 32'h0800_0008, 1'b0, 1'b1};
        tbl[1] = '{2, 32'h2000_0013, 32'h0800_0008, 1'b1, !CS};
        tbl[2] = '{1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1};
        tbl[3] = '{0, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[4] = '{33, 32'h0, 32'h0, 1'b0, 1'b0};
        tbl[5] = '{32, 32'hA5A5_0000, 32'h1234_5678, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", {27'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Non-header byte ignored, then a zero count is an error.
        send_byte(8'h55, 1'b1);
        chk("ign55_state", 32'(u_dut.r_state), 32'(S_IDLE));
        chk("ign55_err", {31'd0, load_err}, 32'd0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        chk_status("n0", 1'b0);

        for (int v = 0; v < 6; v++) begin
            run_frame(tbl[v].n, tbl[v].w0, tbl[v].w1, tbl[v].bad, 1'b0);
            chk_status($sformatf("tbl%0d", v), tbl[v].exp_done);
        end

        // Stop-bit framing error inside DATA.
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        chk_status("ferr", 1'b0);
        run_frame(2, 32'h0BAD_F00D, 32'h7654_3210, 1'b0, 1'b1);
        chk_status("after_ferr", 1'b1);

        // Reload from DONE: header reasserts cpu_reset.
        send_byte(8'hA5, 1'b1);
        chk("reload_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("reload_done", {31'd0, load_done}, 32'd0);
        begin
            logic [7:0]  rb[$];
            logic [31:0] rw;
            wr_t         e;
            rw = 32'h0010_0093;
            rb.push_back(8'h01);
            for (int j = 0; j < 4; j++) rb.push_back(rw[8*j +: 8]);
            if (CS) rb.push_back(rw[7:0] ^ rw[15:8] ^ rw[23:16] ^ rw[31:24]);
            e.addr = 5'd0;
            e.data = rw;
            sb.push_back(e);
            for (int i = 0; i < rb.size() - 1; i++) send_byte(rb[i], 1'b1);
            fork
                send_byte(rb[rb.size() - 1], 1'b1);
                watch_done();
            join
        end
        chk_status("reload", 1'b1);

        // Asynchronous reset in the middle of DATA.
        begin
            wr_t e;
            e.addr = 5'd0;
            e.data = 32'h4433_2211;
            sb.push_back(e);
            send_byte(8'hA5, 1'b1);
            send_byte(8'h02, 1'b1);
            send_byte(8'h11, 1'b1);
            send_byte(8'h22, 1'b1);
            send_byte(8'h33, 1'b1);
            send_byte(8'h44, 1'b1);
            send_byte(8'h55, 1'b1);
        end
        chk("pre_rst_addr", {27'd0, imem_addr}, 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_we", {31'd0, imem_we}, 32'd0);
        chk("arst_addr", {27'd0, imem_addr}, 32'd0);
        chk("arst_wdata", imem_wdata, 32'd0);
        chk("arst_cpurst", {31'd0, cpu_reset}, 32'd1);
        chk("arst_done", {31'd0, load_done}, 32'd0);
        chk("arst_err", {31'd0, load_err}, 32'd0);
        chk("arst_state", 32'(u_dut.r_state), 32'(S_IDLE));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        chk("post_rst_idle", 32'(u_dut.r_state), 32'(S_IDLE));
        run_frame(1, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
        chk_status("post_rst", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
